// File: rtl/lvds_rx_align.sv
// 7:1 LVDS receive word aligner. It finds the clock-lane bit offset and applies that rotation to every lane.
// Define LVDS_RX_ALIGN_ERRCNT_EN to build the lifetime clock-lane mismatch counter that drives err_total.
module lvds_rx_align #(
    parameter int unsigned LANES       = 6,
    parameter int unsigned CLK_LANE    = 5,
    parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned ERR_LIMIT   = 4
) (
    input  logic                 pclk,
    input  logic                 reset_n,
    input  logic [7*LANES-1:0]   din,
    output logic [7*LANES-1:0]   q,
    output logic                 valid,
    output logic                 locked,
    output logic [2:0]           rot,
    output logic                 lock_lost,
    output logic [15:0]          err_total
);

    localparam int MCW = $clog2(LOCK_COUNT + 1);
    localparam int ECW = $clog2(ERR_LIMIT + 1);
    localparam logic [MCW-1:0] LOCK_CNT_MAX = MCW'(LOCK_COUNT);
    localparam logic [ECW-1:0] ERR_CNT_MAX  = ECW'(ERR_LIMIT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               rot_q, rot_d, rotNext;
    logic [MCW-1:0]           matchCnt_q, matchCnt_d;
    logic [ECW-1:0]           errCnt_q, errCnt_d;
    logic                     lockLost_q, lockLost_d;
    logic                     valid_q;
    logic [LANES-1:0][6:0]    prev_q;
    logic [LANES-1:0][6:0]    curWord;
    logic [LANES-1:0][6:0]    window;
    logic [7*LANES-1:0]       q_q, q_d;
    logic                     clkMatch;

    // Each lane's window is a 7-bit slice of {current word, previous word}, starting at the shared offset.
    always_comb begin
        curWord = '0;
        window  = '0;
        q_d     = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < 7; k++) begin
                curWord[i][k] = din[LANES*k + i];
            end
            window[i] = 7'({curWord[i], prev_q[i]} >> rot_q);
            for (int k = 0; k < 7; k++) begin
                q_d[LANES*k + i] = window[i][k];
            end
        end
    end

    assign clkMatch = (window[CLK_LANE] == CLK_PATTERN);

    always_comb begin
        state_d    = state_q;
        rot_d      = rot_q;
        matchCnt_d = matchCnt_q;
        errCnt_d   = errCnt_q;
        lockLost_d = 1'b0;
        rotNext    = (rot_q == 3'd6) ? 3'd0 : rot_q + 3'd1;
        case (state_q)
            SEARCH: begin
                if (clkMatch) begin
                    if (LOCK_COUNT == 1) begin
                        state_d    = LOCKED;
                        matchCnt_d = '0;
                        errCnt_d   = '0;
                    end else begin
                        state_d    = CHECK;
                        matchCnt_d = MCW'(1);
                    end
                end else begin
                    rot_d = rotNext;
                end
            end
            CHECK: begin
                if (clkMatch) begin
                    if (matchCnt_q + MCW'(1) == LOCK_CNT_MAX) begin
                        state_d    = LOCKED;
                        matchCnt_d = '0;
                        errCnt_d   = '0;
                    end else begin
                        matchCnt_d = matchCnt_q + MCW'(1);
                    end
                end else begin
                    state_d    = SEARCH;
                    rot_d      = rotNext;
                    matchCnt_d = '0;
                end
            end
            LOCKED: begin
                // Offset stays frozen while locked and is kept when lock drops, so the rescan resumes here.
                if (clkMatch) begin
                    errCnt_d = '0;
                end else if (errCnt_q + ECW'(1) == ERR_CNT_MAX) begin
                    state_d    = SEARCH;
                    errCnt_d   = '0;
                    matchCnt_d = '0;
                    lockLost_d = 1'b1;
                end else begin
                    errCnt_d = errCnt_q + ECW'(1);
                end
            end
            default: begin
                state_d    = SEARCH;
                matchCnt_d = '0;
                errCnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            state_q    <= SEARCH;
            rot_q      <= 3'd0;
            matchCnt_q <= '0;
            errCnt_q   <= '0;
            lockLost_q <= 1'b0;
            valid_q    <= 1'b0;
            prev_q     <= '0;
            q_q        <= '0;
        end else begin
            state_q    <= state_d;
            rot_q      <= rot_d;
            matchCnt_q <= matchCnt_d;
            errCnt_q   <= errCnt_d;
            lockLost_q <= lockLost_d;
            valid_q    <= (state_q == LOCKED);
            prev_q     <= curWord;
            q_q        <= q_d;
        end
    end

`ifdef LVDS_RX_ALIGN_ERRCNT_EN
    logic [15:0] errTotal_q, errTotal_d;

    always_comb begin
        errTotal_d = errTotal_q;
        if (state_q == LOCKED && !clkMatch && errTotal_q != 16'hFFFF) begin
            errTotal_d = errTotal_q + 16'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset_n) begin
            errTotal_q <= 16'h0000;
        end else begin
            errTotal_q <= errTotal_d;
        end
    end

    assign err_total = errTotal_q;
`else
    assign err_total = 16'h0000;
`endif

    assign q         = q_q;
    assign valid     = valid_q;
    assign locked    = (state_q == LOCKED);
    assign rot       = rot_q;
    assign lock_lost = lockLost_q;

endmodule

// File: doc/lvds_rx_align.md
Name: lvds_rx_align

Overview:
- Receive-side word aligner for the 7:1 LVDS video link.
- Takes raw 7-bit words per lane from the IVIDEO deserializer primitives, which run on the same pclk.
- Uses the clock lane's 1100011 pattern to find the bit-rotation offset, then rotates every lane by that offset.
- Outputs aligned words in the same lane/slot packing the transmit serializer consumes, so the TX and RX bus formats match.

Parameters:
- LANES, 6, total lanes including the clock lane.
- CLK_LANE, 5, index of the lane carrying the clock pattern.
- CLK_PATTERN, 7'b1100011, expected clock-lane word; bit k = slot k (slot 0 is sent first).
- LOCK_COUNT, 16, consecutive clock-lane matches required to declare lock (≥1).
- ERR_LIMIT, 4, consecutive clock-lane mismatches in LOCKED that drop lock (≥1).

Ports:
- pclk  in  1  pixel clock; all logic is on its rising edge.
- reset_n  in  1  synchronous reset, active-low.
- din  in  7*LANES  raw deserialized words; lane i slot k at din[LANES*k+i].
- q  out  7*LANES  aligned words, same packing as din.
- valid  out  1  q holds aligned data (the locked state, delayed to match q).
- locked  out  1  FSM is in LOCKED.
- rot  out  3  current rotation offset, 0..6.
- lock_lost  out  1  one-cycle pulse when LOCKED→SEARCH.
- err_total  out  16  lifetime mismatch count (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at a pclk edge), all registers cleared:
  - q=0, valid=0, locked=0, rot=0, lock_lost=0, err_total=0, state=SEARCH.
  - prev word register=0; match counter and error counter = 0.
- Stream assembly, per lane:
  - prev_i registers the lane's word each cycle.
  - 14-bit stream s_i = {cur_i, prev_i}; prev occupies bits 6:0 (older).
  - Window w_i = s_i[rot+6 : rot].
- Output:
  - q lane i slot k = w_i[k], registered.
  - Latency from din to q is 2 cycles: prev register + output register.
  - valid = locked registered once, so it is aligned with q.
- Match: clock-lane window w_CLK_LANE == CLK_PATTERN, evaluated combinationally using the current rot.
- State SEARCH:
  - match → CHECK, match_cnt=1. If LOCK_COUNT==1, go to LOCKED directly.
  - mismatch → rot = (rot==6) ? 0 : rot+1. Stay in SEARCH; no timeout, scans forever.
- State CHECK:
  - match → match_cnt+1. When match_cnt reaches LOCK_COUNT → LOCKED, err_cnt=0.
  - mismatch → SEARCH, rot advances by 1 (mod 7), match_cnt=0.
- State LOCKED:
  - locked=1; rot is frozen.
  - match → err_cnt=0.
  - mismatch → err_cnt+1. When err_cnt reaches ERR_LIMIT → SEARCH, lock_lost=1 for one cycle, locked=0.
  - rot is kept on re-entry to SEARCH; the scan resumes from that offset.
- Counter widths:
  - match_cnt is clog2(LOCK_COUNT+1) bits.
  - err_cnt is clog2(ERR_LIMIT+1) bits.
  - Neither can exceed its limit; both are reset on each state change.
- Non-clock lanes never affect the FSM.
- Reset mid-operation has priority over every transition, including a simultaneous lock_lost.

Optional Feature:
- Macro: LVDS_RX_ALIGN_ERRCNT_EN.
- Defined: err_total increments on every clock-lane mismatch while in LOCKED, saturates at 16'hFFFF, and is cleared only by reset.
- Undefined: err_total is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset check: hold reset_n=0 for 3 cycles with random din → q=0, valid=0, locked=0, rot=0, lock_lost=0, err_total=0.
- Lock at offset 3: feed a clock-lane bitstream of 1100011 repeated, shifted so the correct offset is 3, with LOCK_COUNT=16.
  - rot steps 0→1→2→3 with one cycle per step.
  - locked rises LOCK_COUNT cycles after rot first reaches 3 with a match.
  - rot stays at 3.
- Data alignment: once locked, inject lane 0 word 7'h55 and lane 2 word 7'h2A at the same bit offset → q lane 0 = 7'h55 and lane 2 = 7'h2A, 2 cycles later, with valid=1.
- Transient glitch: while locked, corrupt 3 consecutive clock words (ERR_LIMIT=4), then resume good pattern → locked stays 1, lock_lost never pulses, err_total=3 (macro on).
- Loss of lock: corrupt 4 consecutive words → lock_lost pulses on the 4th, locked=0, FSM re-scans starting from rot=3; a restored pattern relocks at rot=3.
- Reset mid-lock: assert reset_n=0 one cycle while locked → all outputs return to their reset values on the next edge; a full re-search follows.
